// File: rtl/skip_init_mc_if.sv
// Lane bundle between the skip initializer and the skip datapath.
// master drives the per-lane tokens and data; slave (the initializer) returns flags.
interface skip_init_mc_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) ();
    logic [NUM_CH-1:0]        i_valid;
    logic [NUM_CH-1:0]        i_aux;
    logic [NUM_CH-1:0]        i_rls;
    logic [NUM_CH-1:0]        i_shared;
    logic [NUM_CH-1:0]        i_nonzero;
    logic [NUM_CH-1:0]        i_sent;
    logic [NUM_CH*DATA_W-1:0] i_data;
    logic [NUM_CH-1:0]        o_ready;
    logic [NUM_CH-1:0]        o_store;
    logic [NUM_CH-1:0]        o_zero;
    logic [NUM_CH-1:0]        o_shared;
    logic [NUM_CH-1:0]        o_send_szero;
    logic [NUM_CH-1:0]        o_send_snzero;
    logic [NUM_CH-1:0]        o_run_noshared;
    logic [NUM_CH*DATA_W-1:0] o_sdata;
    logic [NUM_CH*CNT_W-1:0]  o_skip_cnt;

    modport master (
        output i_valid, i_aux, i_rls, i_shared, i_nonzero, i_sent, i_data,
        input  o_ready, o_store, o_zero, o_shared, o_send_szero, o_send_snzero,
               o_run_noshared, o_sdata, o_skip_cnt
    );

    modport slave (
        input  i_valid, i_aux, i_rls, i_shared, i_nonzero, i_sent, i_data,
        output o_ready, o_store, o_zero, o_shared, o_send_szero, o_send_snzero,
               o_run_noshared, o_sdata, o_skip_cnt
    );
endinterface

// File: rtl/skip_init_mc.sv
// Multi-lane skip initializer: per lane, classifies the aux block header (no-shared,
// shared-zero, shared-nonzero), captures the shared word, sequences the init FSM and
// counts valid words seen in RUN (saturating).
// Optional: define SKIP_INIT_ONESHOT_EN to make the shared sends one-cycle pulses per block.
module skip_init_mc #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input logic           clock,
    input logic           reset,
    skip_init_mc_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StZero, StNzro, StRun} state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic              valid, aux, rls, shared, nonzero, sent;
        logic [DATA_W-1:0] data;

        state_e            state_q, state_d;
        logic              r_valid_q;
        logic              kick_ns_q, kick_ns_d;
        logic              kick_z_q, kick_z_d;
        logic              kick_nz_q, kick_nz_d;
        logic              stored_q, stored_d;
        logic [DATA_W-1:0] sdata_q, sdata_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              store, any_kick, hdr, send_z_raw, send_nz_raw, send_z, send_nz;

        assign valid   = bus_io.i_valid[k];
        assign aux     = bus_io.i_aux[k];
        assign rls     = bus_io.i_rls[k];
        assign shared  = bus_io.i_shared[k];
        assign nonzero = bus_io.i_nonzero[k];
        assign sent    = bus_io.i_sent[k];
        assign data    = bus_io.i_data[k*DATA_W +: DATA_W];

        assign any_kick = kick_ns_q | kick_z_q | kick_nz_q;
        // A header only classifies a lane that holds no pending classification, which keeps
        // the kick registers one-hot even when a no-shared lane idles in IDLE.
        assign hdr      = (state_q == StIdle) & aux & valid & ~any_kick;
        assign store    = ~stored_q & (kick_z_q | kick_nz_q) & valid;

        // Init FSM next state; release beats every other transition outside IDLE.
        always_comb begin
            state_d = state_q;
            case (state_q)
                StIdle: begin
                    if (kick_z_q)       state_d = StZero;
                    else if (kick_nz_q) state_d = StNzro;
                end
                StZero:  state_d = rls ? StIdle : (r_valid_q ? StRun : StZero);
                StNzro:  state_d = rls ? StIdle : (valid ? StRun : StNzro);
                StRun:   state_d = rls ? StIdle : StRun;
                default: state_d = StIdle;
            endcase
        end

        // Kick, store and counter next state.
        always_comb begin
            kick_ns_d = kick_ns_q;
            kick_z_d  = kick_z_q;
            kick_nz_d = kick_nz_q;
            stored_d  = stored_q;
            sdata_d   = sdata_q;
            cnt_d     = cnt_q;
            if (rls | sent) begin
                kick_ns_d = 1'b0;
                kick_z_d  = 1'b0;
                kick_nz_d = 1'b0;
            end else if (hdr) begin
                kick_z_d  = shared & ~nonzero;
                kick_nz_d = shared & nonzero;
                kick_ns_d = ~shared;
            end
            if (store) sdata_d = data;
            // Data is still captured on a release cycle; only the stored flag drops.
            if (rls)        stored_d = 1'b0;
            else if (store) stored_d = 1'b1;
            if (rls || (state_d == StRun && state_q != StRun)) begin
                cnt_d = '0;
            end else if (state_q == StRun && valid && cnt_q != CntMax) begin
                cnt_d = cnt_q + CntOne;
            end
        end

        // Lane state registers.
        always_ff @(posedge clock) begin
            if (reset) begin
                state_q   <= StIdle;
                r_valid_q <= 1'b0;
                kick_ns_q <= 1'b0;
                kick_z_q  <= 1'b0;
                kick_nz_q <= 1'b0;
                stored_q  <= 1'b0;
                sdata_q   <= '0;
                cnt_q     <= '0;
            end else begin
                state_q   <= state_d;
                r_valid_q <= valid;
                kick_ns_q <= kick_ns_d;
                kick_z_q  <= kick_z_d;
                kick_nz_q <= kick_nz_d;
                stored_q  <= stored_d;
                sdata_q   <= sdata_d;
                cnt_q     <= cnt_d;
            end
        end

        assign send_z_raw  = stored_q & kick_z_q & ((state_q == StZero) | (state_q == StRun));
        assign send_nz_raw = stored_q & kick_nz_q & ((state_q == StNzro) | (state_q == StRun));

`ifdef SKIP_INIT_ONESHOT_EN
        logic sent_z_q, sent_nz_q;

        assign send_z  = send_z_raw & ~sent_z_q;
        assign send_nz = send_nz_raw & ~sent_nz_q;

        // Remember that this block's send already fired so it pulses once.
        always_ff @(posedge clock) begin
            if (reset || rls) begin
                sent_z_q  <= 1'b0;
                sent_nz_q <= 1'b0;
            end else begin
                if (send_z)  sent_z_q  <= 1'b1;
                if (send_nz) sent_nz_q <= 1'b1;
            end
        end
`else
        assign send_z  = send_z_raw;
        assign send_nz = send_nz_raw;
`endif

        assign bus_io.o_ready[k]        = ((state_q == StIdle) & (kick_z_q | kick_nz_q)) |
                                          (state_q != StIdle) | kick_ns_q;
        assign bus_io.o_store[k]        = store;
        assign bus_io.o_zero[k]         = (state_q == StZero) | kick_z_q;
        assign bus_io.o_shared[k]       = (state_q == StRun);
        assign bus_io.o_send_szero[k]   = send_z;
        assign bus_io.o_send_snzero[k]  = send_nz;
        assign bus_io.o_run_noshared[k] = kick_ns_q;
        assign bus_io.o_sdata[k*DATA_W +: DATA_W] = sdata_q;
        assign bus_io.o_skip_cnt[k*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_skip_init_mc.sv
// Bench for skip_init_mc: directed lane scenarios plus randomized traffic against a
// behavioural per-lane model (pending classification, block phase, held word, count).
module tb_skip_init_mc;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int CntMax = (1 << CNT_W) - 1;
    localparam int ModeNone = 0, ModeNs = 1, ModeZ = 2, ModeNz = 3;
    localparam int PhIdle = 0, PhWaitZ = 1, PhWaitNz = 2, PhRun = 3;
    localparam int FW = 7 * NUM_CH;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    skip_init_mc_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    skip_init_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clock = ~clock;

    // Behavioural model state per lane.
    int                m_mode   [NUM_CH];
    int                m_phase  [NUM_CH];
    bit                m_have   [NUM_CH];
    bit                m_pvalid [NUM_CH];
    bit                m_fz     [NUM_CH];
    bit                m_fnz    [NUM_CH];
    int                m_count  [NUM_CH];
    logic [DATA_W-1:0] m_word   [NUM_CH];

    logic [FW-1:0]            ef;
    logic [NUM_CH*DATA_W-1:0] es;
    logic [NUM_CH*CNT_W-1:0]  ec;

    function automatic bit m_sz(int k);
        bit s = m_have[k] && m_mode[k] == ModeZ && (m_phase[k] == PhWaitZ || m_phase[k] == PhRun);
`ifdef SKIP_INIT_ONESHOT_EN
        s = s && !m_fz[k];
`endif
        return s;
    endfunction

    function automatic bit m_snz(int k);
        bit s = m_have[k] && m_mode[k] == ModeNz && (m_phase[k] == PhWaitNz || m_phase[k] == PhRun);
`ifdef SKIP_INIT_ONESHOT_EN
        s = s && !m_fnz[k];
`endif
        return s;
    endfunction

    function automatic bit m_store(int k);
        return !m_have[k] && (m_mode[k] == ModeZ || m_mode[k] == ModeNz) && bus.i_valid[k];
    endfunction

    // Expected outputs for the current model state and the inputs now on the bus.
    function automatic void model_outs();
        logic [NUM_CH-1:0] rd, st, zr, sh, sz, snz, ns;
        for (int k = 0; k < NUM_CH; k++) begin
            rd[k]  = m_phase[k] != PhIdle || m_mode[k] != ModeNone;
            st[k]  = m_store(k);
            zr[k]  = m_phase[k] == PhWaitZ || m_mode[k] == ModeZ;
            sh[k]  = m_phase[k] == PhRun;
            sz[k]  = m_sz(k);
            snz[k] = m_snz(k);
            ns[k]  = m_mode[k] == ModeNs;
            es[k*DATA_W +: DATA_W] = m_word[k];
            ec[k*CNT_W +: CNT_W]   = CNT_W'(m_count[k]);
        end
        ef = {rd, st, zr, sh, sz, snz, ns};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_mode[k] = ModeNone; m_phase[k] = PhIdle; m_have[k] = 0; m_pvalid[k] = 0;
            m_fz[k] = 0; m_fnz[k] = 0; m_count[k] = 0; m_word[k] = '0;
        end
    endfunction

    // One clock of the block rules, from the inputs present at the edge.
    function automatic void model_step();
        for (int k = 0; k < NUM_CH; k++) begin
            bit v = bus.i_valid[k], rls = bus.i_rls[k];
            bit st = m_store(k), sz = m_sz(k), snz = m_snz(k);
            int nmode = m_mode[k], nphase = m_phase[k];
            if (rls || bus.i_sent[k]) nmode = ModeNone;
            else if (m_phase[k] == PhIdle && bus.i_aux[k] && v && m_mode[k] == ModeNone)
                nmode = bus.i_shared[k] ? (bus.i_nonzero[k] ? ModeNz : ModeZ) : ModeNs;
            if (rls && m_phase[k] != PhIdle) nphase = PhIdle;
            else if (m_phase[k] == PhIdle && m_mode[k] == ModeZ) nphase = PhWaitZ;
            else if (m_phase[k] == PhIdle && m_mode[k] == ModeNz) nphase = PhWaitNz;
            else if (m_phase[k] == PhWaitZ && m_pvalid[k]) nphase = PhRun;
            else if (m_phase[k] == PhWaitNz && v) nphase = PhRun;
            if (rls || (nphase == PhRun && m_phase[k] != PhRun)) m_count[k] = 0;
            else if (m_phase[k] == PhRun && v && m_count[k] < CntMax) m_count[k]++;
            if (st) m_word[k] = bus.i_data[k*DATA_W +: DATA_W];
            if (rls) m_have[k] = 0; else if (st) m_have[k] = 1;
            if (rls) begin m_fz[k] = 0; m_fnz[k] = 0; end
            else begin if (sz) m_fz[k] = 1; if (snz) m_fnz[k] = 1; end
            m_pvalid[k] = v;
            m_mode[k] = nmode;
            m_phase[k] = nphase;
        end
    endfunction

    task automatic clear_inputs();
        bus.i_valid = '0; bus.i_aux = '0; bus.i_rls = '0; bus.i_shared = '0;
        bus.i_nonzero = '0; bus.i_sent = '0; bus.i_data = '0;
    endtask

    // Move to the next cycle: model follows the edge, bench resumes at the falling edge.
    task automatic advance();
        @(posedge clock);
        if (reset) model_reset(); else model_step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        advance();
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({bus.o_ready, bus.o_store, bus.o_zero, bus.o_shared, bus.o_send_szero,
             bus.o_send_snzero, bus.o_run_noshared} !== '0) begin
            errors++; $display("FAIL reset_flags: got %h want 0", {bus.o_ready, bus.o_zero});
        end
        checks++;
        if (bus.o_sdata !== '0) begin
            errors++; $display("FAIL reset_sdata: got %h want 0", bus.o_sdata);
        end
        checks++;
        if (bus.o_skip_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt: got %h want 0", bus.o_skip_cnt);
        end
    endtask

    task automatic test_noshared();
        do_reset();
        bus.i_aux[0] = 1; bus.i_valid[0] = 1; bus.i_shared[0] = 0;
        advance();
        clear_inputs();
        #1;
        checks++;
        if ({bus.o_run_noshared[0], bus.o_ready[0], bus.o_zero[0], bus.o_shared[0]} !== 4'b1100)
        begin
            errors++; $display("FAIL noshared_c1: got %b want 1100",
                {bus.o_run_noshared[0], bus.o_ready[0], bus.o_zero[0], bus.o_shared[0]});
        end
        repeat (4) advance();
        bus.i_sent[0] = 1;
        #1;
        checks++;
        if ({bus.o_run_noshared[0], bus.o_shared[0]} !== 2'b10) begin
            errors++; $display("FAIL noshared_c5: got %b want 10",
                {bus.o_run_noshared[0], bus.o_shared[0]});
        end
        advance();
        clear_inputs();
        #1;
        checks++;
        if ({bus.o_run_noshared[0], bus.o_ready[0]} !== 2'b00) begin
            errors++; $display("FAIL noshared_sent: got %b want 00",
                {bus.o_run_noshared[0], bus.o_ready[0]});
        end
    endtask

    task automatic test_shared_zero();
        logic exp_send;
        do_reset();
        bus.i_aux[1] = 1; bus.i_valid[1] = 1; bus.i_shared[1] = 1; bus.i_nonzero[1] = 0;
        bus.i_data[DATA_W +: DATA_W] = 32'h0000_0000;
        advance();
        bus.i_aux[1] = 0;
        #1;
        checks++;
        if ({bus.o_store[1], bus.o_zero[1], bus.o_ready[1]} !== 3'b111) begin
            errors++; $display("FAIL szero_c1: got %b want 111",
                {bus.o_store[1], bus.o_zero[1], bus.o_ready[1]});
        end
        advance();
        bus.i_valid[1] = 0;
        #1;
        checks++;
        if ({bus.o_zero[1], bus.o_shared[1], bus.o_send_szero[1], bus.o_store[1]} !== 4'b1010 ||
            bus.o_sdata[DATA_W +: DATA_W] !== 32'h0) begin
            errors++; $display("FAIL szero_c2: got %b sdata %h want 1010 sdata 0",
                {bus.o_zero[1], bus.o_shared[1], bus.o_send_szero[1], bus.o_store[1]},
                bus.o_sdata[DATA_W +: DATA_W]);
        end
`ifdef SKIP_INIT_ONESHOT_EN
        exp_send = 1'b0;
`else
        exp_send = 1'b1;
`endif
        for (int c = 0; c < 4; c++) begin
            advance();
            #1;
            checks++;
            if ({bus.o_shared[1], bus.o_send_szero[1]} !== {1'b1, exp_send}) begin
                errors++; $display("FAIL szero_run%0d: got %b want %b", c,
                    {bus.o_shared[1], bus.o_send_szero[1]}, {1'b1, exp_send});
            end
        end
        bus.i_rls[1] = 1;
        advance();
        clear_inputs();
        #1;
        checks++;
        if ({bus.o_shared[1], bus.o_send_szero[1], bus.o_zero[1]} !== 3'b000) begin
            errors++; $display("FAIL szero_rls: got %b want 000",
                {bus.o_shared[1], bus.o_send_szero[1], bus.o_zero[1]});
        end
    endtask

    task automatic test_nonzero_sat();
        do_reset();
        bus.i_aux[2] = 1; bus.i_valid[2] = 1; bus.i_shared[2] = 1; bus.i_nonzero[2] = 1;
        bus.i_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        advance();
        bus.i_aux[2] = 0;
        advance();
        bus.i_valid[2] = 0;
        bus.i_data = '0;
        advance();
        bus.i_valid[2] = 1;
        #1;
        checks++;
        if ({bus.o_ready[2], bus.o_shared[2], bus.o_send_snzero[2]} !== 3'b101 ||
            bus.o_sdata[2*DATA_W +: DATA_W] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL snz_wait: got %b sdata %h want 101 sdata deadbeef",
                {bus.o_ready[2], bus.o_shared[2], bus.o_send_snzero[2]},
                bus.o_sdata[2*DATA_W +: DATA_W]);
        end
        advance();
        #1;
        checks++;
        if (bus.o_shared[2] !== 1'b1 || bus.o_skip_cnt[2*CNT_W +: CNT_W] !== 8'd0) begin
            errors++; $display("FAIL snz_run: got shared %b cnt %0d want 1 0",
                bus.o_shared[2], bus.o_skip_cnt[2*CNT_W +: CNT_W]);
        end
        repeat (100) advance();
        #1;
        checks++;
        if (bus.o_skip_cnt[2*CNT_W +: CNT_W] !== 8'd100) begin
            errors++; $display("FAIL snz_cnt100: got %0d want 100",
                bus.o_skip_cnt[2*CNT_W +: CNT_W]);
        end
        repeat (200) advance();
        #1;
        checks++;
        if (bus.o_skip_cnt[2*CNT_W +: CNT_W] !== 8'd255) begin
            errors++; $display("FAIL snz_sat: got %0d want 255",
                bus.o_skip_cnt[2*CNT_W +: CNT_W]);
        end
    endtask

    task automatic kick_all_lanes();
        do_reset();
        bus.i_aux = '1; bus.i_valid = '1; bus.i_shared = 4'b1110; bus.i_nonzero = 4'b1100;
        bus.i_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_concurrency();
        kick_all_lanes();
        for (int c = 0; c < 8; c++) begin
            #1;
            model_outs();
            checks++;
            if ({bus.o_ready, bus.o_store, bus.o_zero, bus.o_shared, bus.o_send_szero,
                 bus.o_send_snzero, bus.o_run_noshared} !== ef || bus.o_sdata !== es) begin
                errors++; $display("FAIL conc_c%0d: got %h/%h want %h/%h", c,
                    {bus.o_ready, bus.o_store, bus.o_zero, bus.o_shared, bus.o_send_szero,
                     bus.o_send_snzero, bus.o_run_noshared}, bus.o_sdata, ef, es);
            end
            advance();
            bus.i_aux = '0;
        end
        bus.i_rls[3] = 1;
        advance();
        bus.i_rls = '0;
        #1;
        checks++;
        if (bus.o_shared !== 4'b0110 || bus.o_run_noshared !== 4'b0001 ||
            bus.o_skip_cnt[3*CNT_W +: CNT_W] !== 8'd0) begin
            errors++; $display("FAIL conc_rls: got shared %b ns %b cnt3 %0d want 0110 0001 0",
                bus.o_shared, bus.o_run_noshared, bus.o_skip_cnt[3*CNT_W +: CNT_W]);
        end
        model_outs();
        checks++;
        if (bus.o_skip_cnt !== ec || bus.o_sdata !== es) begin
            errors++; $display("FAIL conc_others: got %h/%h want %h/%h",
                bus.o_skip_cnt, bus.o_sdata, ec, es);
        end
    endtask

    task automatic test_reset_mid_run();
        kick_all_lanes();
        repeat (10) begin
            advance();
            bus.i_aux = '0;
        end
        reset = 1'b1;
        advance();
        #1;
        checks++;
        if ({bus.o_ready, bus.o_store, bus.o_zero, bus.o_shared, bus.o_send_szero,
             bus.o_send_snzero, bus.o_run_noshared} !== '0 || bus.o_sdata !== '0 ||
            bus.o_skip_cnt !== '0) begin
            errors++; $display("FAIL midrun_reset: got %h/%h/%h want all 0",
                {bus.o_ready, bus.o_zero, bus.o_shared}, bus.o_sdata, bus.o_skip_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.i_aux     = NUM_CH'($urandom);
            bus.i_valid   = NUM_CH'($urandom);
            bus.i_shared  = NUM_CH'($urandom);
            bus.i_nonzero = NUM_CH'($urandom);
            bus.i_rls     = NUM_CH'($urandom & $urandom & $urandom & $urandom);
            bus.i_sent    = NUM_CH'($urandom & $urandom & $urandom & $urandom);
            bus.i_data    = {$urandom, $urandom, $urandom, $urandom};
            #1;
            model_outs();
            checks++;
            if ({bus.o_ready, bus.o_store, bus.o_zero, bus.o_shared, bus.o_send_szero,
                 bus.o_send_snzero, bus.o_run_noshared} !== ef) begin
                errors++; $display("FAIL rand_flags c%0d: got %h want %h", c,
                    {bus.o_ready, bus.o_store, bus.o_zero, bus.o_shared, bus.o_send_szero,
                     bus.o_send_snzero, bus.o_run_noshared}, ef);
            end
            checks++;
            if (bus.o_sdata !== es) begin
                errors++; $display("FAIL rand_sdata c%0d: got %h want %h", c, bus.o_sdata, es);
            end
            checks++;
            if (bus.o_skip_cnt !== ec) begin
                errors++; $display("FAIL rand_cnt c%0d: got %h want %h", c, bus.o_skip_cnt, ec);
            end
            advance();
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        @(negedge clock);
        test_reset();
        test_noshared();
        test_shared_zero();
        test_nonzero_sat();
        test_concurrency();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
